// File: rtl/sqrt_share_arb.sv
// Round-robin arbiter sharing one multi-cycle square-root core among NUM_REQ requesters.
// One transaction at a time: ARB -> ISSUE -> WAIT -> RESP, with a WAIT watchdog.
module sqrt_share_arb #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH / 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [OUT_WIDTH-1:0]          rsp_root,
  output logic                          rsp_neg,
  output logic                          rsp_err,
  output logic                          core_start,
  output logic [IN_WIDTH-1:0]           core_x,
  input  logic [OUT_WIDTH-1:0]          core_y,
  input  logic                          core_done,
  input  logic                          core_is_neg,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic                          err_sticky
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [2:0]           last_grant;
  logic [IN_WIDTH-1:0]  operand;
  logic [CW-1:0]        wait_cnt;

  logic                 win_found;
  logic [2:0]           win_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IN_WIDTH-1:0]  win_data;
  logic [NUM_REQ-1:0]   grant_oh;

  // Scan candidates in order last_grant+1, +2, ...; the first valid one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_data  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] &&
            i == (32'(last_grant) + k) % NUM_REQ) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
          win_oh[i] = 1'b1;
          win_data  = req_data[i*IN_WIDTH +: IN_WIDTH];
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (32'(grant_id) == i);
    end
  end

  assign req_ready = (state == ARB && !rst) ? win_oh : '0;
  assign busy      = (state != ARB);
  assign core_x    = operand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= 3'(NUM_REQ - 1);
      operand    <= '0;
      wait_cnt   <= '0;
      grant_id   <= '0;
      err_sticky <= 1'b0;
      rsp_valid  <= '0;
      rsp_root   <= '0;
      rsp_neg    <= 1'b0;
      rsp_err    <= 1'b0;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      unique case (state)
        ARB: begin
          if (win_found) begin
            operand    <= win_data;
            grant_id   <= win_idx;
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_root  <= core_y;
            rsp_neg   <= core_is_neg;
            rsp_err   <= 1'b0;
            rsp_valid <= grant_oh;
            state     <= RESP;
          end else if (32'(wait_cnt) == TIMEOUT - 1) begin
            // TIMEOUT-th WAIT cycle without completion: abort with an error response.
            rsp_root   <= '0;
            rsp_neg    <= 1'b0;
            rsp_err    <= 1'b1;
            err_sticky <= 1'b1;
            rsp_valid  <= grant_oh;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid  <= '0;
            last_grant <= grant_id;
            state      <= ARB;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_arb.sv
// Directed bench for sqrt_share_arb with a behavioural 16-cycle square-root core.
module tb_sqrt_share_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [15:0]  rsp_root;
  logic         rsp_neg;
  logic         rsp_err;
  logic         core_start;
  logic [31:0]  core_x;
  logic [15:0]  core_y;
  logic         core_done;
  logic         core_is_neg;
  logic         busy;
  logic [2:0]   grant_id;
  logic         err_sticky;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = -1;
  int start_count = 0;
  logic core_en;
  int run_cnt;

  sqrt_share_arb #(.NUM_REQ(4), .IN_WIDTH(32), .OUT_WIDTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_root(rsp_root), .rsp_neg(rsp_neg), .rsp_err(rsp_err),
    .core_start(core_start), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .core_is_neg(core_is_neg),
    .busy(busy), .grant_id(grant_id), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      start_cyc   <= cyc;
      start_count <= start_count + 1;
    end
  end

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [63:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // Core: start sampled at the edge ending cycle 1, done pulse during cycle 18.
  always @(posedge clk) begin
    if (rst) begin
      run_cnt     <= 0;
      core_done   <= 1'b0;
      core_y      <= '0;
      core_is_neg <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (core_start && core_en) begin
        run_cnt     <= 16;
        core_y      <= core_x[31] ? 16'd0 : isqrt(core_x);
        core_is_neg <= core_x[31];
      end else if (run_cnt == 1) begin
        core_done <= 1'b1;
        run_cnt   <= 0;
      end else if (run_cnt != 0) begin
        run_cnt <= run_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  task automatic wait_rsp(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        at = cyc;
        break;
      end
    end
    chk("rsp_arrived", 64'(at >= 0), 64'd1);
  endtask

  task automatic do_rsp(input logic [3:0] mask);
    rsp_ready = mask;
    @(negedge clk);
    rsp_ready = '0;
    #1;
  endtask

  initial begin
    int c0, at, sc, bad;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = '0;
    core_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_root", rsp_root, 0);
    chk("rst_neg", rsp_neg, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_sticky", err_sticky, 0);

    // Single request, latency
    @(negedge clk);
    set_data(0, 32'd144);
    req_valid = 4'b0001;
    #1;
    chk("s_ready", req_ready, 4'b0001);
    c0 = cyc;
    @(negedge clk); #1;
    chk("s_start", core_start, 1);
    chk("s_busy", busy, 1);
    chk("s_ready_issue", req_ready, 0);
    chk("s_corex", core_x, 144);
    req_valid = '0;
    wait_rsp(40, at);
    chk("s_lat_start", 64'(start_cyc - c0), 1);
    chk("s_lat_rsp", 64'(at - c0), 19);
    chk("s_valid", rsp_valid, 4'b0001);
    chk("s_root", rsp_root, 12);
    chk("s_neg", rsp_neg, 0);
    chk("s_err", rsp_err, 0);
    chk("s_gid", grant_id, 0);
    do_rsp(4'b0001);
    chk("s_idle", busy, 0);
    chk("s_valid_clr", rsp_valid, 0);

    // Negative radicand; non-granted rsp_ready ignored
    set_data(2, -32'sd5);
    req_valid = 4'b0100;
    #1;
    chk("n_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, at);
    chk("n_valid", rsp_valid, 4'b0100);
    chk("n_root", rsp_root, 0);
    chk("n_neg", rsp_neg, 1);
    rsp_ready = 4'b1011;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("n_other_ready", rsp_valid, 4'b0100);
    chk("n_still_busy", busy, 1);
    do_rsp(4'b0100);
    chk("n_done", rsp_valid, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r2_gid", grant_id, 0);
    chk("r2_corex", core_x, 0);
    chk("r2_neg", rsp_neg, 0);

    // Fairness with all requesters continuously valid
    set_data(0, 32'd1);
    set_data(1, 32'd4);
    set_data(2, 32'd9);
    set_data(3, 32'd16);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      chk("f_ready", req_ready, 64'(1 << g));
      @(negedge clk); #1;
      chk("f_ready_busy", req_ready, 0);
      wait_rsp(40, at);
      chk("f_valid", rsp_valid, 64'(1 << g));
      chk("f_gid", grant_id, 64'(g));
      chk("f_root", rsp_root, 64'(g + 1));
      do_rsp(4'b1111);
    end
    req_valid = '0;

    // Backpressure on requester 1
    set_data(1, 32'd49);
    req_valid = 4'b0010;
    #1;
    chk("b_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = 4'b1101;
    wait_rsp(40, at);
    sc = start_count;
    for (int k = 0; k < 10; k++) begin
      chk("b_valid_hold", rsp_valid, 4'b0010);
      chk("b_root_hold", rsp_root, 7);
      chk("b_ready_zero", req_ready, 0);
      @(negedge clk); #1;
    end
    chk("b_no_start", 64'(start_count), 64'(sc));
    req_valid = '0;
    do_rsp(4'b0010);
    chk("b_done", rsp_valid, 0);

    // Timeout: core never completes
    core_en = 1'b0;
    set_data(3, 32'd100);
    req_valid = 4'b1000;
    #1;
    chk("t_ready", req_ready, 4'b1000);
    c0 = cyc;
    sc = start_count;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(100, at);
    chk("t_lat", 64'(at - c0), 66);
    chk("t_started", 64'(start_count), 64'(sc + 1));
    chk("t_valid", rsp_valid, 4'b1000);
    chk("t_err", rsp_err, 1);
    chk("t_root", rsp_root, 0);
    chk("t_neg", rsp_neg, 0);
    chk("t_sticky", err_sticky, 1);
    do_rsp(4'b1000);
    core_en = 1'b1;
    set_data(0, 32'd256);
    req_valid = 4'b0001;
    #1;
    chk("t2_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, at);
    chk("t2_root", rsp_root, 16);
    chk("t2_err", rsp_err, 0);
    chk("t2_sticky", err_sticky, 1);
    do_rsp(4'b0001);

    // Reset mid-WAIT
    set_data(1, 32'd81);
    req_valid = 4'b0010;
    #1;
    chk("m_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("m_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("m_busy_rst", busy, 0);
    chk("m_valid_rst", rsp_valid, 0);
    chk("m_sticky_rst", err_sticky, 0);
    chk("m_gid_rst", grant_id, 0);
    chk("m_corex_rst", core_x, 0);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid != '0) bad++;
    end
    chk("m_no_rsp", 64'(bad), 0);
    req_valid = 4'b0011;
    #1;
    chk("m_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(40, at);
    chk("m_valid", rsp_valid, 4'b0001);
    chk("m_root", rsp_root, 16);
    do_rsp(4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
